// File: rtl/decoder2to4_pulse.sv
// 2-to-4 one-hot decoder that stretches each accepted code into a timed pulse,
// followed by an optional all-zero gap before the next code is taken.
module decoder2to4_pulse #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [3:0] dout,
  output logic       dout_valid,
  output logic       busy,
  output logic [7:0] dec_count
);

  // state | meaning
  // IDLE  | waiting for a code; ready when en = 1
  // HOLD  | one-hot pulse on dout for HOLD_CYCLES cycles
  // GAP   | dout forced to zero for GAP_CYCLES cycles
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       cnt_zero;
  logic       accept;

  assign cnt_zero = (cnt == 8'd0);
  assign accept   = din_valid & din_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = HOLD;
      HOLD: if (cnt_zero) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:  if (cnt_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    din_ready = (state == IDLE) && en;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 8'd0;
      dout       <= 4'b0000;
      dout_valid <= 1'b0;
      dec_count  <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            dout       <= 4'b0001 << din;
            dout_valid <= 1'b1;
            cnt        <= HOLD_LOAD;
            dec_count  <= dec_count + 8'd1;
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            dout       <= 4'b0000;
            dout_valid <= 1'b0;
            cnt        <= GAP_LOAD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (!cnt_zero) cnt <= cnt - 8'd1;
        end
        default: begin
          cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule
